// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/result bundle between a multiply requester and seq_multiplier
interface seq_multiplier_if #(
    parameter int WIDTH = 16
) ();
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    modport master (
        output start,
        output A,
        output B,
        input  busy,
        input  done,
        input  P
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output busy,
        output done,
        output P
    );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - unsigned shift-add multiplier, one partial product per clock
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_multiplier_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_d;
    logic [CW-1:0]        cnt_d;
    logic                 last_iter;

    // The carry of the high-half add becomes the new MSB after the shift,
    // so an all-ones operand pair never loses its top bit.
    always_comb begin
        addend    = b_q[0] ? a_q : '0;
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_d     = {sum, acc_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CW'(1);
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_d;
                    // Fixed iteration count: no early exit on zero multiplier bits.
                    if (last_iter) begin
                        p_q     <= acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.P    = p_q;
endmodule
